// File: rtl/ps_tdm_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : ps_tdm_serializer
//  Brief    : Double-buffered parallel-to-serial TDM/I2S transmitter. Takes one
//             frame of NCH samples over valid/ready and shifts it out MSB-first
//             on BCLK_EN ticks, with optional one-bit I2S delay and
//             underrun / frame-resync pulses.
//  Options  : PS_TDM_UNDERRUN_REPEAT_EN - when defined, an underrun re-sends
//             the previously transmitted frame instead of a zero frame.
//  Revision : 1.0 - initial release
// ============================================================================
module ps_tdm_serializer #(
   parameter int DATA_W = 16,
   parameter int SLOT_W = 32,
   parameter int NCH    = 2
) (
   input  logic                  MCLK,
   input  logic                  RST_N,
   input  logic                  BCLK_EN,
   input  logic                  FS_START,
   input  logic                  DELAY,
   input  logic [NCH*DATA_W-1:0] IN_DATA,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   output logic                  SDATA,
   output logic                  BUSY,
   output logic                  UNDERRUN,
   output logic                  FRAME_ERR
);

   localparam int FRAME_BITS = NCH * SLOT_W;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(FRAME_BITS);

   // Holding register (upstream side of the double buffer)
   logic [NCH*DATA_W-1:0] hold_data;
   logic                  hold_full;

   // Shift side: remaining frame bits sit at the top of shift_reg
   logic [FRAME_BITS-1:0] shift_reg;
   logic [CNT_W-1:0]      bit_cnt;     // frame bits already emitted
   logic                  busy;
   logic                  d_lat;       // DELAY latched at frame start
   logic                  delay_bit;   // previous direct bit, for I2S delay

   logic                  sdata_q;
   logic                  underrun_q;
   logic                  frame_err_q;

   logic                  start_tick;
   logic                  accept;
   logic [FRAME_BITS-1:0] hold_frame;
   logic [FRAME_BITS-1:0] fill_frame;
   logic [FRAME_BITS-1:0] new_frame;
   logic                  direct_bit;
   logic                  d_eff;
   logic                  out_bit;

   assign start_tick = BCLK_EN & FS_START;
   assign accept     = IN_VALID & ~hold_full;

`ifdef PS_TDM_UNDERRUN_REPEAT_EN
   logic [FRAME_BITS-1:0] last_frame;

   // Remember every frame that was loaded so an underrun can replay it
   always_ff @(posedge MCLK or negedge RST_N) begin
      if (!RST_N) begin
         last_frame <= '0;
      end else if (start_tick) begin
         last_frame <= new_frame;
      end
   end

   assign fill_frame = last_frame;
`else
   assign fill_frame = '0;
`endif

   // Spread the packed samples into slots: sample at the top, zero padding below
   always_comb begin
      hold_frame = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         hold_frame[(NCH-1-ch)*SLOT_W + (SLOT_W-DATA_W) +: DATA_W] =
            hold_data[(NCH-1-ch)*DATA_W +: DATA_W];
      end
   end

   // Select the bit leaving the frame this tick and apply the optional delay
   always_comb begin
      new_frame  = hold_full ? hold_frame : fill_frame;
      direct_bit = 1'b0;
      if (start_tick) begin
         direct_bit = new_frame[FRAME_BITS-1];
      end else if (busy) begin
         direct_bit = shift_reg[FRAME_BITS-1];
      end
      // The frame-start tick already obeys the newly sampled DELAY
      d_eff   = start_tick ? DELAY : d_lat;
      out_bit = d_eff ? delay_bit : direct_bit;
   end

   // Holding register: a frame start empties it; a same-cycle handshake
   // (only possible when it was already empty) refills it for the next frame
   always_ff @(posedge MCLK or negedge RST_N) begin
      if (!RST_N) begin
         hold_data <= '0;
         hold_full <= 1'b0;
      end else begin
         if (accept) begin
            hold_data <= IN_DATA;
         end
         if (start_tick) begin
            hold_full <= accept;
         end else if (accept) begin
            hold_full <= 1'b1;
         end
      end
   end

   // Shift register, bit counter and delay tap advance on every bit tick
   always_ff @(posedge MCLK or negedge RST_N) begin
      if (!RST_N) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         busy      <= 1'b0;
         d_lat     <= 1'b0;
         delay_bit <= 1'b0;
      end else if (BCLK_EN) begin
         delay_bit <= direct_bit;
         if (start_tick) begin
            // Bit 0 leaves on this tick, so one bit is already emitted
            shift_reg <= new_frame << 1;
            bit_cnt   <= CNT_W'(1);
            busy      <= (CNT_W'(1) != CNT_END);
            d_lat     <= DELAY;
         end else if (busy) begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            busy      <= ((bit_cnt + CNT_W'(1)) != CNT_END);
         end
      end
   end

   // Registered serial output and single-cycle status pulses
   always_ff @(posedge MCLK or negedge RST_N) begin
      if (!RST_N) begin
         sdata_q     <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (BCLK_EN) begin
            sdata_q <= out_bit;
         end
         underrun_q  <= start_tick & ~hold_full;
         frame_err_q <= start_tick & busy & (bit_cnt != CNT_END);
      end
   end

   assign IN_READY  = ~hold_full;
   assign SDATA     = sdata_q;
   assign BUSY      = busy;
   assign UNDERRUN  = underrun_q;
   assign FRAME_ERR = frame_err_q;

endmodule
`default_nettype wire

// File: doc/ps_tdm_serializer.md
# ps_tdm_serializer

Parametrised parallel-to-serial converter for the audio output path: accepts one frame of NCH PCM samples over a valid/ready handshake and shifts it out MSB-first on a single TDM/I2S serial line. Bit and frame timing come from the clock/frame generator as single-MCLK enable pulses. Adds double buffering, configurable slot width and channel count, selectable I2S one-bit delay, and underrun/resync reporting.

## Interface

- DATA_W, 16: sample width in bits; 1 ≤ DATA_W ≤ SLOT_W.
- SLOT_W, 32: bit slots per channel; bits after the sample are padded with zeros.
- NCH, 2: channels per frame; 1..16.
- MCLK  in  1  master clock; all logic is clocked on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- BCLK_EN  in  1  one-MCLK pulse per serial bit; marks the shift instant.
- FS_START  in  1  frame start; qualified only when BCLK_EN=1.
- DELAY  in  1  1 = I2S one-bit delay; 0 = left-justified/TDM. Sampled at frame start.
- IN_DATA  in  NCH*DATA_W  frame; channel 0 occupies the top DATA_W bits.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  holding register is empty.
- SDATA  out  1  serial output, registered.
- BUSY  out  1  a frame is shifting.
- UNDERRUN  out  1  one-cycle pulse: a frame started with no data held.
- FRAME_ERR  out  1  one-cycle pulse: FS_START arrived before the frame completed.

## Operation

- Reset values: SDATA=0, IN_READY=1, BUSY=0, UNDERRUN=0, FRAME_ERR=0. The holding register, shift register, delay bit and bit counter all clear to 0.
- Holding register:
  - IN_READY = not hold_full.
  - On IN_VALID & IN_READY, IN_DATA is captured and hold_full is set.
- Frame start (tick = BCLK_EN & FS_START):
  - The shift frame (NCH*SLOT_W bits) is loaded from the holding register. Each channel slot is the sample followed by SLOT_W-DATA_W zeros.
  - hold_full clears, bit counter resets to 0, BUSY sets, and DELAY is latched as D.
  - If the holding register is empty, UNDERRUN pulses and a zero frame is loaded.
  - If BUSY was set and the counter had not reached NCH*SLOT_W, FRAME_ERR pulses. The old frame is abandoned and the new frame starts; this is the resync path.
- Shifting (every BCLK_EN, including the frame-start tick):
  - The direct bit is the next frame bit, MSB of channel 0 first.
  - The delay register captures the direct bit.
  - SDATA takes the direct bit if D=0, or the previous delay-register value if D=1.
- The counter increments per BCLK_EN tick. When it reaches NCH*SLOT_W, BUSY clears and the direct bit is 0 until the next frame start. With D=1, the final frame bit still emerges one tick later.
- Simultaneous events:
  - If a handshake happens in the same cycle as a frame-start tick while the holding register is empty, UNDERRUN still fires. The accepted word is held for the next frame.
  - If the holding register is full at a frame-start tick and IN_VALID=1 in the same cycle, the word is not accepted, because IN_READY was 0 in that cycle.
- FS_START without BCLK_EN is ignored.
- An RST_N assertion mid-frame immediately returns every output to its reset value. The partial frame is discarded.

## Timing

- SDATA changes only on the MCLK edge that samples BCLK_EN=1.
- Latency with D=0: frame bit k appears on SDATA one MCLK after tick k, where tick 0 is FS_START. With D=1 it appears one MCLK after tick k+1.
- IN_READY rises one MCLK after the frame-start tick that empties the holding register.
- Throughput: one frame per NCH*SLOT_W ticks. Upstream has a full frame period to refill the holding register.
- UNDERRUN and FRAME_ERR are registered and asserted one MCLK after the triggering tick.

## Configuration

- PS_TDM_UNDERRUN_REPEAT_EN
  - Defined: on underrun, the previously transmitted frame is re-sent. After reset that frame is all zeros. UNDERRUN still pulses.
  - Undefined: on underrun, a zero frame is sent.

## Test plan

All scenarios use DATA_W=16, SLOT_W=32, NCH=2, DELAY=0 unless stated.

- Basic frame: load 0xA5C3_1234, then FS_START tick -> SDATA over 64 ticks = A5C3 MSB-first, 16 zeros, 1234, 16 zeros. BUSY high for 64 ticks. IN_READY returns to 1.
- I2S delay: same data with DELAY=1 -> the stream lags by one tick. The first SDATA bit equals the prior frame's last bit (0). Bit 1 of A5C3's MSB-first sequence appears at tick 1.
- Underrun: FS_START tick with the holding register empty -> UNDERRUN single pulse and 64 zero bits. The repeat-macro build instead re-sends the last frame, 0xA5C3_1234.
- Back-to-back: present a new frame 0xFFFF_0001 during frame N -> it is accepted mid-frame and frame N+1 starts exactly at the next FS_START with no gap. No UNDERRUN.
- Resync: FS_START at tick 20 of a frame -> FRAME_ERR pulse, counter restarts at 0, and the new frame's MSB is output.
- Reset mid-frame: RST_N low at tick 30 -> SDATA=0, BUSY=0, IN_READY=1 immediately. After release, the first FS_START sends an underrun zero frame.
